// File: rtl/syscall_halt_ctrl_if.sv
// ============================================================================
// Module      : syscall_halt_ctrl_if
// Description : Decode/regfile-side bundle for the SYSCALL PC sequencer.
//               The slave modport is the sequencer; the master modport is the
//               surrounding datapath (or a bench) that drives it.
//               Optional step_i exists only when SINGLE_STEP_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface syscall_halt_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             syscall_i;
   logic [31:0]      v0_i;
   logic [31:0]      a0_i;
   logic             go_i;
`ifdef SINGLE_STEP_EN
   logic             step_i;
`endif
   logic             pc_en_o;
   logic             halted_o;
   logic [31:0]      disp_o;
   logic             disp_vld_o;
   logic [CNT_W-1:0] cycle_cnt_o;
   logic [CNT_W-1:0] halt_cnt_o;

   modport master (
`ifdef SINGLE_STEP_EN
      output step_i,
`endif
      output syscall_i, v0_i, a0_i, go_i,
      input  pc_en_o, halted_o, disp_o, disp_vld_o, cycle_cnt_o, halt_cnt_o
   );

   modport slave (
`ifdef SINGLE_STEP_EN
      input  step_i,
`endif
      input  syscall_i, v0_i, a0_i, go_i,
      output pc_en_o, halted_o, disp_o, disp_vld_o, cycle_cnt_o, halt_cnt_o
   );
endinterface

`default_nettype wire

// File: rtl/syscall_halt_ctrl.sv
// ============================================================================
// Module      : syscall_halt_ctrl
// Description : PC write-enable sequencer around SYSCALL. A display service
//               (v0 == SHOW_CODE) latches a0 into the display register and
//               keeps running; any other service stalls the PC until a fresh
//               rising edge of the Go button, then retires one instruction.
//               Optional feature macro: SINGLE_STEP_EN (adds bus.step_i).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module syscall_halt_ctrl #(
   parameter logic [31:0] SHOW_CODE = 32'h0000_0022,
   parameter int          CNT_W     = 32
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   syscall_halt_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HALT    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_go_s1;
   logic             r_go_s2;
   logic             r_go_s3;
   logic [31:0]      r_disp;
   logic             r_disp_vld;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_halt_cnt;

   logic             w_go_rise;
   logic             w_halt_req;
   logic             w_show_req;
   logic             w_step_hold;
   logic             w_pc_en;
   logic             w_halted;

   assign w_go_rise  = r_go_s2 & ~r_go_s3;
   assign w_halt_req = bus.syscall_i & (bus.v0_i != SHOW_CODE);
   assign w_show_req = bus.syscall_i & (bus.v0_i == SHOW_CODE);

`ifdef SINGLE_STEP_EN
   logic r_step;

   // Step level is registered so entering/leaving step mode takes effect on the next edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step <= 1'b0;
      end else begin
         r_step <= bus.step_i;
      end
   end

   assign w_step_hold = r_step;
`else
   assign w_step_hold = 1'b0;
`endif

   // Go button: two-flop synchronizer plus a delay flop for rising-edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_go_s1 <= 1'b0;
         r_go_s2 <= 1'b0;
         r_go_s3 <= 1'b0;
      end else begin
         r_go_s1 <= bus.go_i;
         r_go_s2 <= r_go_s1;
         r_go_s3 <= r_go_s2;
      end
   end

   // PC enable and halted flag depend only on state and decode inputs (no go path)
   always_comb begin
      w_pc_en  = 1'b0;
      w_halted = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_pc_en  = ~w_halt_req & ~w_step_hold;
            w_halted = ~w_halt_req &  w_step_hold;
         end
         ST_HALT: begin
            w_halted = 1'b1;
         end
         ST_RELEASE: begin
            w_pc_en  = 1'b1;
         end
         default: begin
            w_pc_en  = 1'b0;
            w_halted = 1'b0;
         end
      endcase
   end

   // Sequencer FSM with display register and halt-entry counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_RUN;
         r_disp     <= 32'd0;
         r_disp_vld <= 1'b0;
         r_halt_cnt <= '0;
      end else begin
         r_disp_vld <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (w_halt_req) begin
                  // The halting syscall itself does not retire here
                  r_state <= ST_HALT;
                  if (~&r_halt_cnt) begin
                     r_halt_cnt <= r_halt_cnt + 1'b1;
                  end
               end else if (w_step_hold) begin
                  // Stepping: nothing retires until the operator presses Go
                  if (w_go_rise) begin
                     r_state <= ST_RELEASE;
                  end
               end else if (w_show_req) begin
                  r_disp     <= bus.a0_i;
                  r_disp_vld <= 1'b1;
               end
            end
            ST_HALT: begin
               // Only a fresh edge releases; a level held since entry has already been consumed
               if (w_go_rise) begin
                  r_state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               r_state <= ST_RUN;
`ifdef SINGLE_STEP_EN
               // A stepped display syscall updates the display as it retires
               if (w_step_hold && w_show_req) begin
                  r_disp     <= bus.a0_i;
                  r_disp_vld <= 1'b1;
               end
`endif
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   // Retired-instruction counter, saturating at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_cnt <= '0;
      end else if (w_pc_en && (~&r_cycle_cnt)) begin
         r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
   end

   assign bus.pc_en_o     = w_pc_en;
   assign bus.halted_o    = w_halted;
   assign bus.disp_o      = r_disp;
   assign bus.disp_vld_o  = r_disp_vld;
   assign bus.cycle_cnt_o = r_cycle_cnt;
   assign bus.halt_cnt_o  = r_halt_cnt;

endmodule

`default_nettype wire

// File: tb/tb_syscall_halt_ctrl.sv
// ============================================================================
// Module      : tb_syscall_halt_ctrl
// Description : Directed self-checking bench for syscall_halt_ctrl.
//               The step-mode section is built only with SINGLE_STEP_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_syscall_halt_ctrl;

   logic clk;
   logic rst_n;

   int          checks;
   int          errors;
   logic        exp_pc;
   logic [31:0] exp_cyc;

   syscall_halt_ctrl_if #(.CNT_W(32)) bus ();

   syscall_halt_ctrl #(
      .SHOW_CODE (32'h0000_0022),
      .CNT_W     (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check pc_en against the expected value for this cycle, clock once, advance model counter
   task automatic tick(input string tag);
      #1;
      check({tag, "_pc_en"}, {31'd0, bus.pc_en_o}, {31'd0, exp_pc});
      @(posedge clk);
      if (exp_pc) exp_cyc = exp_cyc + 32'd1;
      #1;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      exp_pc        = 1'b1;
      exp_cyc       = 32'd0;
      rst_n         = 1'b1;
      bus.syscall_i = 1'b0;
      bus.v0_i      = 32'd0;
      bus.a0_i      = 32'd0;
      bus.go_i      = 1'b0;
`ifdef SINGLE_STEP_EN
      bus.step_i    = 1'b0;
`endif

      // Power-on reset asserted between clock edges
      #2 rst_n = 1'b0;
      #1;
      check("por_pc_en",  {31'd0, bus.pc_en_o},    32'd1);
      check("por_halted", {31'd0, bus.halted_o},   32'd0);
      check("por_disp",   bus.disp_o,              32'd0);
      check("por_vld",    {31'd0, bus.disp_vld_o}, 32'd0);
      check("por_cyc",    bus.cycle_cnt_o,         32'd0);
      check("por_hcnt",   bus.halt_cnt_o,          32'd0);
      #9 rst_n = 1'b1;
      tick("run0");
      check("run0_cyc", bus.cycle_cnt_o, 32'd1);

      // Display service: retires, display updates next edge for one cycle
      bus.syscall_i = 1'b1;
      bus.v0_i      = 32'h0000_0022;
      bus.a0_i      = 32'hDEAD_BEEF;
      tick("show");
      check("show_disp",   bus.disp_o,              32'hDEAD_BEEF);
      check("show_vld",    {31'd0, bus.disp_vld_o}, 32'd1);
      check("show_halted", {31'd0, bus.halted_o},   32'd0);
      bus.syscall_i = 1'b0;
      tick("show_after");
      check("show_vld_drop", {31'd0, bus.disp_vld_o}, 32'd0);
      check("show_disp_hold", bus.disp_o,            32'hDEAD_BEEF);
      check("show_cyc",      bus.cycle_cnt_o,        32'd3);

      // Halting service held: stall immediately, stays halted
      bus.syscall_i = 1'b1;
      bus.v0_i      = 32'h0000_000A;
      bus.a0_i      = 32'h0000_0005;
      exp_pc        = 1'b0;
      tick("halt_entry");
      check("halt_halted", {31'd0, bus.halted_o}, 32'd1);
      check("halt_hcnt",   bus.halt_cnt_o,        32'd1);
      for (int i = 0; i < 100; i++) tick("halt_hold");
      check("halt100_halted", {31'd0, bus.halted_o}, 32'd1);
      check("halt100_cyc",    bus.cycle_cnt_o,       exp_cyc);

      // Go pulse: first sampled at edge k, RELEASE entered at edge k+2
      bus.go_i = 1'b1;
      tick("go_k");
      bus.go_i = 1'b0;
      tick("go_k1");
      check("go_k1_halted", {31'd0, bus.halted_o}, 32'd1);
      tick("go_k2");
      check("rel_halted", {31'd0, bus.halted_o}, 32'd0);
      exp_pc = 1'b1;
      tick("release");
      // Syscall still presented: RUN would re-halt, so pc_en must have dropped
      #1;
      check("rel_one_cycle", {31'd0, bus.pc_en_o}, 32'd0);
      check("rel_hcnt",      bus.halt_cnt_o,       32'd1);
      check("rel_cyc",       bus.cycle_cnt_o,      exp_cyc);
      bus.syscall_i = 1'b0;
      tick("after_rel");
      // Go in RUN is ignored
      bus.go_i = 1'b1;
      tick("run_go");
      bus.go_i = 1'b0;
      for (int i = 0; i < 3; i++) tick("run_go_wait");
      check("run_go_halted", {31'd0, bus.halted_o}, 32'd0);
      check("run_go_hcnt",   bus.halt_cnt_o,        32'd1);
      check("run_go_cyc",    bus.cycle_cnt_o,       exp_cyc);

      // Go held across HALT entry does not release
      bus.go_i = 1'b1;
      for (int i = 0; i < 3; i++) tick("held_pre");
      bus.syscall_i = 1'b1;
      bus.v0_i      = 32'h0000_0001;
      exp_pc        = 1'b0;
      tick("held_entry");
      check("held_halted", {31'd0, bus.halted_o}, 32'd1);
      check("held_hcnt",   bus.halt_cnt_o,        32'd2);
      for (int i = 0; i < 5; i++) tick("held_hold");
      bus.go_i = 1'b0;
      tick("held_low0");
      tick("held_low1");
      check("held_no_release", {31'd0, bus.halted_o}, 32'd1);
      bus.go_i = 1'b1;
      tick("held_k");
      tick("held_k1");
      tick("held_k2");
      check("held_rel_halted", {31'd0, bus.halted_o}, 32'd0);
      bus.syscall_i = 1'b0;
      exp_pc        = 1'b1;
      tick("held_release");
      bus.go_i = 1'b0;
      tick("held_run");
      check("held_run_halted", {31'd0, bus.halted_o}, 32'd0);
      check("held_run_cyc",    bus.cycle_cnt_o,       exp_cyc);

      // Reset mid-HALT with a go edge in flight
      bus.syscall_i = 1'b1;
      bus.v0_i      = 32'h0000_000A;
      exp_pc        = 1'b0;
      tick("mh_entry");
      check("mh_hcnt", bus.halt_cnt_o, 32'd3);
      bus.go_i = 1'b1;
      tick("mh_go");
      rst_n         = 1'b0;
      bus.syscall_i = 1'b0;
      bus.go_i      = 1'b0;
      #1;
      check("mh_pc_en",  {31'd0, bus.pc_en_o},    32'd1);
      check("mh_halted", {31'd0, bus.halted_o},   32'd0);
      check("mh_disp",   bus.disp_o,              32'd0);
      check("mh_vld",    {31'd0, bus.disp_vld_o}, 32'd0);
      check("mh_cyc",    bus.cycle_cnt_o,         32'd0);
      check("mh_hcnt0",  bus.halt_cnt_o,          32'd0);
      exp_cyc = 32'd0;
      #1 rst_n = 1'b1;
      exp_pc = 1'b1;
      for (int i = 0; i < 4; i++) tick("mh_run");
      check("mh_run_halted", {31'd0, bus.halted_o}, 32'd0);
      check("mh_run_cyc",    bus.cycle_cnt_o,       32'd4);
      check("mh_run_hcnt",   bus.halt_cnt_o,        32'd0);

`ifdef SINGLE_STEP_EN
      // Step mode: each go edge retires exactly one instruction
      bus.step_i = 1'b1;
      tick("st_enter");
      exp_pc = 1'b0;
      check("st_halted", {31'd0, bus.halted_o}, 32'd1);
      for (int p = 0; p < 3; p++) begin
         bus.go_i = 1'b1;
         tick("st_k");
         bus.go_i = 1'b0;
         tick("st_k1");
         tick("st_k2");
         check("st_rel_halted", {31'd0, bus.halted_o}, 32'd0);
         exp_pc = 1'b1;
         tick("st_release");
         exp_pc = 1'b0;
         tick("st_idle");
      end
      check("st_cyc", bus.cycle_cnt_o, 32'd8);
      // Display syscall stepped: display updates only as it retires
      bus.syscall_i = 1'b1;
      bus.v0_i      = 32'h0000_0022;
      bus.a0_i      = 32'h0000_1234;
      bus.go_i      = 1'b1;
      tick("sts_k");
      check("sts_no_vld", {31'd0, bus.disp_vld_o}, 32'd0);
      bus.go_i = 1'b0;
      tick("sts_k1");
      tick("sts_k2");
      exp_pc = 1'b1;
      tick("sts_release");
      check("sts_disp", bus.disp_o,              32'h0000_1234);
      check("sts_vld",  {31'd0, bus.disp_vld_o}, 32'd1);
      bus.syscall_i = 1'b0;
      bus.step_i    = 1'b0;
      exp_pc        = 1'b0;
      tick("st_exit");
      exp_pc = 1'b1;
      tick("st_free");
      check("st_free_halted", {31'd0, bus.halted_o}, 32'd0);
      check("st_free_cyc",    bus.cycle_cnt_o,       exp_cyc);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
